multicycle_decoder: RTL and testbench

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

---
 rtl/multicycle_decoder_pkg.sv | 39 +++
 rtl/multicycle_decoder_classifier.sv | 50 +++++
 rtl/multicycle_decoder.sv | 163 ++++++++++++++++
 tb/tb_multicycle_decoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_decoder_pkg.sv
// Shared definitions for the multicycle MIPS-subset decoder: opcode/funct
// values, ALU control encodings, FSM states and instruction classes.
package multicycle_decoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    localparam logic [2:0] ALU_ADD  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b111;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b000;
    localparam logic [2:0] ALU_NONE = 3'b010;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, MULT
    } state_e;

    typedef enum logic [3:0] {
        CL_ILLEGAL, CL_RALU, CL_MFHI, CL_MFLO, CL_MULT, CL_LW,
        CL_SW, CL_BEQ, CL_ADDIU, CL_ORI, CL_J, CL_JAL
    } op_class_e;

endpackage

// File: rtl/multicycle_decoder_classifier.sv
// Combinational instruction classifier: maps the held instruction word to an
// operation class, its ALU control code and an illegal flag.
module instr_classifier
    import multicycle_decoder_pkg::*;
(
    input  logic [31:0] ir,
    output op_class_e   op_class,
    output logic [2:0]  alu_op,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = ir[31:26];
    assign funct         = ir[5:0];
    assign unused_fields = ^ir[25:6];

    always_comb begin
        op_class = CL_ILLEGAL;
        alu_op   = ALU_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin op_class = CL_RALU; alu_op = ALU_ADD;  end
                    FN_SUBU: begin op_class = CL_RALU; alu_op = ALU_SUB;  end
                    FN_AND:  begin op_class = CL_RALU; alu_op = ALU_AND;  end
                    FN_OR:   begin op_class = CL_RALU; alu_op = ALU_OR;   end
                    FN_SLTU: begin op_class = CL_RALU; alu_op = ALU_SLTU; end
                    FN_MFHI: op_class = CL_MFHI;
                    FN_MFLO: op_class = CL_MFLO;
                    FN_MULT: op_class = CL_MULT;
                    default: op_class = CL_ILLEGAL;
                endcase
            end
            OP_LW:    begin op_class = CL_LW;    alu_op = ALU_ADD; end
            OP_SW:    begin op_class = CL_SW;    alu_op = ALU_ADD; end
            OP_ADDIU: begin op_class = CL_ADDIU; alu_op = ALU_ADD; end
            OP_ORI:   begin op_class = CL_ORI;   alu_op = ALU_OR;  end
            OP_BEQ:   begin op_class = CL_BEQ;   alu_op = ALU_SUB; end
            OP_J:     op_class = CL_J;
            OP_JAL:   op_class = CL_JAL;
            default:  op_class = CL_ILLEGAL;
        endcase
    end

    assign illegal = (op_class == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_decoder.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB/MULT sequencer driving
// datapath strobes from the state, the held instruction register and zero.
module multicycle_decoder
    import multicycle_decoder_pkg::*;
#(
    parameter int MULT_LATENCY = 4,
    parameter int ALUCTRL_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 instr_ack,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrcbimm,
    output logic                 dobranch,
    output logic                 dojump,
    output logic                 dolink,
    output logic [4:0]           destreg,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 zeroext_imm,
    output logic                 mult_busy,
    output logic                 hilo_write,
    output logic                 hilo_sel,
    output logic                 illegal
);

    state_e      state;
    logic [31:0] ir;
    logic [3:0]  count;
    logic        rst_d;
    logic        quiet;
    op_class_e   cls;
    logic [2:0]  alu_op;
    logic        cls_illegal;
    logic        rtype;

    instr_classifier u_classifier (
        .ir       (ir),
        .op_class (cls),
        .alu_op   (alu_op),
        .illegal  (cls_illegal)
    );

    // The cycle after reset is kept silent too, so no fetch is accepted then.
    assign quiet = reset | rst_d;
    assign rtype = (cls == CL_RALU) || (cls == CL_MFHI) || (cls == CL_MFLO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ir    <= '0;
            count <= '0;
            rst_d <= 1'b1;
        end else begin
            rst_d <= 1'b0;
            case (state)
                FETCH: begin
                    if (instr_valid && !rst_d) begin
                        ir    <= instr;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (cls_illegal || cls == CL_J || cls == CL_JAL) begin
                        state <= FETCH;
                    end else if (cls == CL_MULT) begin
                        count <= 4'(MULT_LATENCY - 1);
                        state <= MULT;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cls == CL_BEQ)
                        state <= FETCH;
                    else if (cls == CL_LW || cls == CL_SW)
                        state <= MEM;
                    else
                        state <= WB;
                end
                MEM: begin
                    if (mem_ready)
                        state <= (cls == CL_LW) ? WB : FETCH;
                end
                WB: state <= FETCH;
                MULT: begin
                    if (count == 4'd0)
                        state <= FETCH;
                    else
                        count <= count - 4'd1;
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        instr_ack   = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrcbimm  = 1'b0;
        dobranch    = 1'b0;
        dojump      = 1'b0;
        dolink      = 1'b0;
        destreg     = '0;
        alucontrol  = '0;
        zeroext_imm = 1'b0;
        mult_busy   = 1'b0;
        hilo_write  = 1'b0;
        hilo_sel    = 1'b0;
        illegal     = 1'b0;
        if (!quiet) begin
            case (state)
                FETCH: instr_ack = instr_valid;
                DECODE: begin
                    if (cls == CL_J) begin
                        dojump = 1'b1;
                    end else if (cls == CL_JAL) begin
                        dojump   = 1'b1;
                        dolink   = 1'b1;
                        regwrite = 1'b1;
                        destreg  = 5'd31;
                    end else if (cls_illegal) begin
                        illegal = 1'b1;
                    end
                end
                EXEC: begin
                    alucontrol  = ALUCTRL_W'(alu_op);
                    alusrcbimm  = (cls == CL_LW) || (cls == CL_SW) ||
                                  (cls == CL_ADDIU) || (cls == CL_ORI);
                    zeroext_imm = (cls == CL_ORI);
                    dobranch    = (cls == CL_BEQ) && zero;
                end
                MEM: begin
                    alucontrol = ALUCTRL_W'(alu_op);
                    memread    = (cls == CL_LW);
                    memwrite   = (cls == CL_SW);
                end
                WB: begin
                    alucontrol = ALUCTRL_W'(alu_op);
                    regwrite   = 1'b1;
                    destreg    = rtype ? ir[15:11] : ir[20:16];
                    memtoreg   = (cls == CL_LW);
                    hilo_sel   = (cls == CL_MFHI);
                end
                MULT: begin
                    mult_busy  = 1'b1;
                    hilo_write = (count == 4'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed-vector bench for multicycle_decoder: walks each instruction class
// cycle by cycle and compares all outputs against hand-computed values.
module tb_multicycle_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        zero;
    logic        mem_ready;
    logic        instr_ack, memread, memwrite, memtoreg, regwrite, alusrcbimm;
    logic        dobranch, dojump, dolink, zeroext_imm, mult_busy, hilo_write;
    logic        hilo_sel, illegal;
    logic [4:0]  destreg;
    logic [2:0]  alucontrol;

    int checks   = 0;
    int failures = 0;

    // Strobe bit masks, packed in the same order as obs below.
    localparam logic [13:0] ACK = 14'h2000, MR  = 14'h1000, MW  = 14'h0800;
    localparam logic [13:0] MTR = 14'h0400, RW  = 14'h0200, IMM = 14'h0100;
    localparam logic [13:0] BR  = 14'h0080, JMP = 14'h0040, LNK = 14'h0020;
    localparam logic [13:0] ZX  = 14'h0010, BSY = 14'h0008, HW  = 14'h0004;
    localparam logic [13:0] HS  = 14'h0002, ILL = 14'h0001, NONE = 14'h0000;

    logic [21:0] obs;
    assign obs = {instr_ack, memread, memwrite, memtoreg, regwrite, alusrcbimm,
                  dobranch, dojump, dolink, zeroext_imm, mult_busy, hilo_write,
                  hilo_sel, illegal, destreg, alucontrol};

    multicycle_decoder #(.MULT_LATENCY(4), .ALUCTRL_W(3)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .zero(zero), .mem_ready(mem_ready), .instr_ack(instr_ack),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrcbimm(alusrcbimm), .dobranch(dobranch),
        .dojump(dojump), .dolink(dolink), .destreg(destreg),
        .alucontrol(alucontrol), .zeroext_imm(zeroext_imm),
        .mult_busy(mult_busy), .hilo_write(hilo_write), .hilo_sel(hilo_sel),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [21:0] got,
                            input logic [21:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got strobes=%04h dest=%0d alu=%03b  exp strobes=%04h dest=%0d alu=%03b",
                     tag, got[21:8], got[7:3], got[2:0], exp[21:8], exp[7:3], exp[2:0]);
        end
    endtask

    // Check the current cycle's outputs mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [13:0] s,
                       input logic [4:0] d, input logic [2:0] a);
        #1;
        check_eq(tag, obs, {s, d, a});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        cyc(tag, ACK, 5'd0, 3'b000);
        instr_valid = 1'b0;
    endtask

    logic [31:0] rw_instr [4] = '{32'h00221823, 32'h00221824, 32'h00221825, 32'h0022182B};
    logic [2:0]  rw_alu   [4] = '{3'b001, 3'b111, 3'b110, 3'b000};

    initial begin
        reset = 1'b1; instr = 32'h00221821; instr_valid = 1'b1;
        zero = 1'b0; mem_ready = 1'b0;
        cyc("rst_0", NONE, 5'd0, 3'b000);
        cyc("rst_1", NONE, 5'd0, 3'b000);
        reset = 1'b0;
        cyc("post_rst", NONE, 5'd0, 3'b000);

        // addu $3,$1,$2 with instr_valid kept high: no ack outside FETCH
        cyc("addu_f", ACK, 5'd0, 3'b000);
        cyc("addu_d", NONE, 5'd0, 3'b000);
        cyc("addu_e", NONE, 5'd0, 3'b101);
        instr_valid = 1'b0;
        cyc("addu_wb", RW, 5'd3, 3'b101);
        cyc("idle", NONE, 5'd0, 3'b000);

        for (int i = 0; i < 4; i++) begin
            fetch("ralu_f", rw_instr[i]);
            cyc("ralu_d", NONE, 5'd0, 3'b000);
            cyc("ralu_e", NONE, 5'd0, rw_alu[i]);
            cyc("ralu_wb", RW, 5'd3, rw_alu[i]);
        end

        // lw $5,8($4), memory stalls three cycles
        fetch("lw_f", 32'h8C850008);
        cyc("lw_d", NONE, 5'd0, 3'b000);
        cyc("lw_e", IMM, 5'd0, 3'b101);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", MR, 5'd0, 3'b101);
        mem_ready = 1'b1;
        cyc("lw_mem_rdy", MR, 5'd0, 3'b101);
        mem_ready = 1'b0;
        cyc("lw_wb", RW | MTR, 5'd5, 3'b101);

        fetch("beq1_f", 32'h10220004);
        cyc("beq1_d", NONE, 5'd0, 3'b000);
        zero = 1'b1;
        cyc("beq1_e", BR, 5'd0, 3'b001);
        zero = 1'b0;
        fetch("beq0_f", 32'h10220004);
        cyc("beq0_d", NONE, 5'd0, 3'b000);
        cyc("beq0_e", NONE, 5'd0, 3'b001);

        fetch("mult_f", 32'h00220018);
        cyc("mult_d", NONE, 5'd0, 3'b000);
        for (int i = 0; i < 3; i++) cyc("mult_busy", BSY, 5'd0, 3'b000);
        cyc("mult_last", BSY | HW, 5'd0, 3'b000);
        fetch("mfhi_f", 32'h00003810);
        cyc("mfhi_d", NONE, 5'd0, 3'b000);
        cyc("mfhi_e", NONE, 5'd0, 3'b010);
        cyc("mfhi_wb", RW | HS, 5'd7, 3'b010);

        fetch("mflo_f", 32'h00004012);
        cyc("mflo_d", NONE, 5'd0, 3'b000);
        cyc("mflo_e", NONE, 5'd0, 3'b010);
        cyc("mflo_wb", RW, 5'd8, 3'b010);

        fetch("j_f", 32'h08000010);
        cyc("j_d", JMP, 5'd0, 3'b000);
        fetch("jal_f", 32'h0C000010);
        cyc("jal_d", JMP | LNK | RW, 5'd31, 3'b000);

        fetch("ori_f", 32'h350900FF);
        cyc("ori_d", NONE, 5'd0, 3'b000);
        cyc("ori_e", IMM | ZX, 5'd0, 3'b110);
        cyc("ori_wb", RW, 5'd9, 3'b110);

        fetch("addiu0_f", 32'h24200001);
        cyc("addiu0_d", NONE, 5'd0, 3'b000);
        cyc("addiu0_e", IMM, 5'd0, 3'b101);
        cyc("addiu0_wb", RW, 5'd0, 3'b101);

        fetch("ill_op_f", 32'hFC000000);
        cyc("ill_op_d", ILL, 5'd0, 3'b000);
        cyc("ill_op_next", NONE, 5'd0, 3'b000);
        fetch("ill_fn_f", 32'h00000001);
        cyc("ill_fn_d", ILL, 5'd0, 3'b000);

        // sw abandoned by reset while waiting on memory
        fetch("sw_f", 32'hAC850004);
        cyc("sw_d", NONE, 5'd0, 3'b000);
        cyc("sw_e", IMM, 5'd0, 3'b101);
        cyc("sw_mem", MW, 5'd0, 3'b101);
        reset = 1'b1; mem_ready = 1'b1;
        cyc("sw_rst", NONE, 5'd0, 3'b000);
        reset = 1'b0; mem_ready = 1'b0; instr_valid = 1'b1;
        cyc("sw_post_rst", NONE, 5'd0, 3'b000);
        fetch("refetch_f", 32'h08000010);
        cyc("refetch_d", JMP, 5'd0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
